// File: rtl/hdb3_decoder_if.sv
// Line-side symbol strobe and decoded-bit bundle for hdb3_decoder.
// i_bit_en is a one-cycle strobe per symbol with no backpressure; o_valid/o_code_err pulse once per event.
interface hdb3_decoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 i_bit_en;
    logic                 i_pos;
    logic                 i_neg;
    logic                 o_data;
    logic                 o_valid;
    logic                 o_code_err;
    logic [ERR_CNT_W-1:0] o_err_cnt;
    logic [2:0]           dbg_fill;
    logic                 dbg_last_pol;

    modport master (
        output i_bit_en, i_pos, i_neg,
        input  o_data, o_valid, o_code_err, o_err_cnt, dbg_fill, dbg_last_pol
    );

    modport slave (
        input  i_bit_en, i_pos, i_neg,
        output o_data, o_valid, o_code_err, o_err_cnt, dbg_fill, dbg_last_pol
    );
endinterface

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: 4-symbol delay line removes B00V/000V substitutions.
// Define HDB3_ERR_CHECK_EN to compile in code-error detection and the saturating error counter.
module hdb3_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hdb3_decoder_if.slave bus
);
    localparam logic POL_NEG = 1'b0;

    logic [3:0] sr;
    logic [2:0] fill;
    logic       last_pol;
    logic       data_q;
    logic       valid_q;

    logic       is_mark;
    logic       is_v;
    logic       in_bit;
    logic [3:0] sr_next;

    // Mark polarity is i_pos itself (1 = +); a V repeats the previous mark's polarity.
    always_comb begin
        is_mark = bus.i_pos ^ bus.i_neg;
        is_v    = is_mark && (bus.i_pos == last_pol);
        in_bit  = is_mark && !is_v;
        sr_next = is_v ? 4'b0000 : {sr[2:0], in_bit};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr       <= 4'b0000;
            fill     <= 3'd0;
            last_pol <= POL_NEG;
            data_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.i_bit_en) begin
                sr <= sr_next;
                if (is_mark) begin
                    last_pol <= bus.i_pos;
                end
                if (fill == 3'd4) begin
                    valid_q <= 1'b1;
                    data_q  <= sr[3];
                end else begin
                    fill <= fill + 3'd1;
                end
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.dbg_fill     = fill;
    assign bus.dbg_last_pol = last_pol;

`ifdef HDB3_ERR_CHECK_EN
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic                 err_now;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt;

    // A legal V is only ever preceded by two zeros (B00V or 000V).
    assign err_now = (bus.i_pos & bus.i_neg) || (is_v && (sr[1:0] != 2'b00));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_q <= bus.i_bit_en && err_now;
            if (bus.i_bit_en && err_now && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

    assign bus.o_code_err = err_q;
    assign bus.o_err_cnt  = err_cnt;
`else
    assign bus.o_code_err = 1'b0;
    assign bus.o_err_cnt  = {ERR_CNT_W{1'b0}};
`endif
endmodule
